mem_stream_reader: RTL

- Read-side controller for the operand memory: fetches a contiguous block of words from a synchronous-read memory and streams them to the MAC datapath over a valid/ready interface.
- Pairs with the existing write path, which stores operands via clocked D-flip-flop storage; this block is the consumer end.
- Handles 1-cycle memory read latency and downstream backpressure without losing or duplicating words.

---
 rtl/mem_stream_reader.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// Block-read controller: fetches `length` words from a 1-cycle-latency memory and streams them over valid/ready.
// Optional build macro MEM_STREAM_READER_PARITY_EN adds out_parity (even parity of out_data).
module mem_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef MEM_STREAM_READER_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [LEN_W-1:0]       rd_left_r;
    logic [LEN_W-1:0]       push_left_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic                   inflight_r;
    logic                   busy_r;
    logic                   done_r;

    // Two-entry FIFO; e0 is the head. A word returning from memory is visible at the output the same cycle.
    logic                   e0_valid_r, e1_valid_r, e0_last_r, e1_last_r;
    logic [DATA_WIDTH-1:0]  e0_data_r, e1_data_r;
    logic                   e0_valid_s, e1_valid_s, e0_last_s, e1_last_s;
    logic [DATA_WIDTH-1:0]  e0_data_s, e1_data_s;

    logic                   start_ok_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   push_last_s;
    logic                   issue_s;
    logic [1:0]             occ_s;
    logic                   out_valid_s;
    logic                   out_last_s;
    logic [DATA_WIDTH-1:0]  out_data_s;
    logic                   busy_s;
    logic                   done_s;

`ifdef MEM_STREAM_READER_PARITY_EN
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign start_ok_s  = start && (state_r == IDLE);
    assign push_s      = inflight_r;
    assign push_last_s = inflight_r && (push_left_r == LEN_W'(1));
    assign out_valid_s = e0_valid_r | inflight_r;
    assign pop_s       = out_valid_s && out_ready;
    assign occ_s       = {1'b0, e0_valid_r} + {1'b0, e1_valid_r} + {1'b0, inflight_r};
    // A same-cycle pop frees a slot, which keeps the stream at one word per cycle.
    assign issue_s     = (state_r == FETCH) && (rd_left_r != LEN_W'(0)) &&
                         ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));

    // Output word selection: stored head first, otherwise the word arriving from memory.
    always_comb begin
        out_data_s = {DATA_WIDTH{1'b0}};
        out_last_s = 1'b0;
        if (e0_valid_r) begin
            out_data_s = e0_data_r;
            out_last_s = e0_last_r;
        end else if (inflight_r) begin
            out_data_s = mem_rd_data;
            out_last_s = push_last_s;
        end else begin
            out_data_s = {DATA_WIDTH{1'b0}};
            out_last_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (length == LEN_W'(0)) ? DONE : FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (issue_s && (rd_left_r == LEN_W'(1))) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DRAIN: begin
                if (pop_s && out_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, decoded from the upcoming state so they register in step with it.
    always_comb begin
        busy_s = (state_nxt_s != IDLE);
        done_s = (state_nxt_s == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Block parameters, read address and the two word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_left_r   <= LEN_W'(0);
            push_left_r <= LEN_W'(0);
            addr_r      <= ADDR_WIDTH'(0);
            inflight_r  <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (start_ok_s) begin
                rd_left_r   <= length;
                push_left_r <= length;
                addr_r      <= base_addr;
            end else begin
                if (issue_s) begin
                    rd_left_r <= rd_left_r - LEN_W'(1);
                    addr_r    <= addr_r + ADDR_WIDTH'(1);
                end
                if (push_s) begin
                    push_left_r <= push_left_r - LEN_W'(1);
                end
            end
        end
    end

    // FIFO next state: order is e0, e1, then the arriving word; a pop removes the front.
    always_comb begin
        e0_valid_s = e0_valid_r;
        e0_data_s  = e0_data_r;
        e0_last_s  = e0_last_r;
        e1_valid_s = e1_valid_r;
        e1_data_s  = e1_data_r;
        e1_last_s  = e1_last_r;
        if (pop_s) begin
            if (e0_valid_r) begin
                if (e1_valid_r) begin
                    e0_data_s = e1_data_r;
                    e0_last_s = e1_last_r;
                    if (push_s) begin
                        e1_data_s = mem_rd_data;
                        e1_last_s = push_last_s;
                    end else begin
                        e1_valid_s = 1'b0;
                    end
                end else if (push_s) begin
                    e0_data_s = mem_rd_data;
                    e0_last_s = push_last_s;
                end else begin
                    e0_valid_s = 1'b0;
                end
            end else begin
                e0_valid_s = 1'b0;
                e1_valid_s = 1'b0;
            end
        end else if (push_s) begin
            if (e0_valid_r) begin
                e1_valid_s = 1'b1;
                e1_data_s  = mem_rd_data;
                e1_last_s  = push_last_s;
            end else begin
                e0_valid_s = 1'b1;
                e0_data_s  = mem_rd_data;
                e0_last_s  = push_last_s;
            end
        end else begin
            e0_valid_s = e0_valid_r;
        end
    end

    // FIFO storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_valid_r <= 1'b0;
            e0_data_r  <= {DATA_WIDTH{1'b0}};
            e0_last_r  <= 1'b0;
            e1_valid_r <= 1'b0;
            e1_data_r  <= {DATA_WIDTH{1'b0}};
            e1_last_r  <= 1'b0;
        end else begin
            e0_valid_r <= e0_valid_s;
            e0_data_r  <= e0_data_s;
            e0_last_r  <= e0_last_s;
            e1_valid_r <= e1_valid_s;
            e1_data_r  <= e1_data_s;
            e1_last_r  <= e1_last_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign mem_rd_en = issue_s;
    assign mem_addr  = addr_r;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_last  = out_last_s;
`ifdef MEM_STREAM_READER_PARITY_EN
    assign out_parity = parity_of(out_data_s);
`endif

endmodule
